// File: rtl/cpu_selftest_sequencer.sv
// Run/check controller for the single-cycle RISC-V core: reset, run to halt or budget,
// then freeze the core and compare architectural registers against an expected table.
module cpu_selftest_sequencer #(
    parameter int          XLEN       = 32,
    parameter int          NUM_CHECKS = 18,
    parameter int          MAX_CYCLES = 30,
    parameter int          RST_HOLD   = 2,
    parameter logic [31:0] HALT_INSN  = 32'h00000063,
    parameter int          IW         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    parameter int          CW         = $clog2(MAX_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            cpu_rst,
    output logic            cpu_en,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    output logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic [IW-1:0]   exp_idx,
    input  logic [4:0]      exp_addr,
    input  logic [XLEN-1:0] exp_value,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [IW:0]     fail_count,
    output logic [IW-1:0]   first_fail_idx,
    output logic [CW-1:0]   cycle_count
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD - 1);
    localparam logic [CW-1:0] BUDGET_LAST = CW'(MAX_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_CHECKS - 1);
    localparam logic [IW:0]   FAIL_MAX    = (IW + 1)'(NUM_CHECKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [HW-1:0]   hold_cnt;
    logic [XLEN-1:0] halt_pc;

    logic start_ok;
    logic is_halt;
    logic budget_hit;
    logic hold_last;
    logic idx_last;
    logic mismatch;

    assign start_ok   = start && (state == S_IDLE || state == S_DONE);
    assign is_halt    = (instr == HALT_INSN);
    assign budget_hit = (cycle_count == BUDGET_LAST);
    assign hold_last  = (hold_cnt == HOLD_LAST);
    assign idx_last   = (exp_idx == IDX_LAST);
    assign mismatch   = (dbg_data != exp_value);

    // halt_pc is a debug-only observation point with no consumer in this block.
    logic unused_halt_pc;
    assign unused_halt_pc = ^halt_pc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_ok) next_state = S_RESET;
            S_RESET: if (hold_last) next_state = S_RUN;
            S_RUN:   if (is_halt || budget_hit) next_state = S_CHECK;
            S_CHECK: if (idx_last) next_state = S_DONE;
            S_DONE:  if (start_ok) next_state = S_RESET;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_en   = (state == S_RESET) || (state == S_RUN);
        busy     = (state == S_RESET) || (state == S_RUN) || (state == S_CHECK);
        done     = (state == S_DONE);
        dbg_addr = (state == S_CHECK) ? exp_addr : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rst        <= 1'b0;
            hold_cnt       <= '0;
            cycle_count    <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            exp_idx        <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            halt_pc        <= '0;
        end else begin
            // Core stays out of reset through CHECK/DONE so its register file survives.
            cpu_rst <= (next_state == S_RUN) || (next_state == S_CHECK) ||
                       (next_state == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        hold_cnt       <= '0;
                        cycle_count    <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        exp_idx        <= '0;
                        timeout        <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (!hold_last) hold_cnt <= hold_cnt + 1'b1;
                end
                S_RUN: begin
                    if (is_halt) begin
                        halt_pc <= pc;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                        if (budget_hit) begin
                            timeout <= 1'b1;
                            halt_pc <= pc;
                        end
                    end
                end
                S_CHECK: begin
                    if (mismatch && fail_count != FAIL_MAX) begin
                        fail_count <= fail_count + 1'b1;
                        if (fail_count == '0) first_fail_idx <= exp_idx;
                    end
                    if (idx_last) begin
                        pass <= !timeout && (fail_count == '0) && !mismatch;
                    end else begin
                        exp_idx <= exp_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
